// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Contains the FSM state encoding, the byte-enable codes and a lane-enable helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_WAIT = 2'd1,
    DR_RESP = 2'd2
  } dr_state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

  // Byte lanes to write this cycle; nothing is written unless the store is allowed.
  function automatic logic [1:0] be_write_lanes(input logic en, input logic [1:0] be);
    logic [1:0] lanes;
    lanes = BE_NONE;
    if (en) begin
      case (be)
        BE_LO:   lanes = BE_LO;
        BE_HI:   lanes = BE_HI;
        BE_ALL:  lanes = BE_ALL;
        default: lanes = BE_NONE;
      endcase
    end
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 16 data storage split into two byte lanes, each with its own
// write enable and a registered read port. Contents start at zero.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  input  logic [1:0]    wr_lanes,
  input  logic [15:0]   wr_data,
  output logic [15:0]   rd_data
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem_reg [DEPTH] = '{default: 8'h00};
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (wr_lanes[gi]) begin
        mem_reg[addr] <= wr_data[gi*8 +: 8];
      end
      if (rd_en) begin
        rd_reg <= mem_reg[addr];
      end
    end
  end

  assign rd_data = {g_lane[1].rd_reg, g_lane[0].rd_reg};

endmodule

// File: rtl/dmem_responder.sv
// Responder for the pipeline data-memory port: one request at a time,
// WAIT_CYCLES wait states, byte-enabled access, held response until accepted.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  dr_state_t   state_reg;
  dr_state_t   state_next;
  logic [15:0] cnt_reg;
  logic        we_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [1:0]  be_reg;

  logic        out_of_range;
  logic        access;
  logic        rd_en;
  logic [1:0]  wr_lanes;
  logic [15:0] rd_data;

  // Any address bit above the array index makes the access out of range.
  assign out_of_range = (addr_reg >> AW) != 16'd0;
  assign access       = (state_reg == DR_WAIT) && (cnt_reg == 16'd0);
  assign rd_en        = access && !we_reg && !out_of_range;
  assign wr_lanes     = be_write_lanes(access && we_reg && !out_of_range, be_reg);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk      (clk),
    .addr     (addr_reg[AW-1:0]),
    .rd_en    (rd_en),
    .wr_lanes (wr_lanes),
    .wr_data  (wdata_reg),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DR_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= 16'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 16'd0;
      wdata_reg <= 16'd0;
      be_reg    <= BE_NONE;
    end else if ((state_reg == DR_IDLE) && bus.req_valid) begin
      cnt_reg   <= 16'(WAIT_CYCLES);
      we_reg    <= bus.req_we;
      addr_reg  <= bus.req_addr;
      wdata_reg <= bus.req_wdata;
      be_reg    <= bus.req_be;
    end else if ((state_reg == DR_WAIT) && (cnt_reg != 16'd0)) begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DR_IDLE: if (bus.req_valid)     state_next = DR_WAIT;
      DR_WAIT: if (cnt_reg == 16'd0)  state_next = DR_RESP;
      DR_RESP: if (bus.resp_ready)    state_next = DR_IDLE;
      default:                        state_next = DR_IDLE;
    endcase
  end

  // Response fields are derived from held capture registers, so they stay
  // stable through backpressure and drop to zero as soon as RESP is left.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 16'd0;
    bus.resp_err   = 1'b0;
    busy           = 1'b1;
    case (state_reg)
      DR_IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
      end
      DR_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = out_of_range;
        bus.resp_rdata = (we_reg || out_of_range) ? 16'd0 : rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with two
// wait states, one with none, sharing clock and reset.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  logic busy_a;
  logic busy_b;
  int   checks;
  int   failures;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a),
    .busy  (busy_a)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b),
    .busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request on bus_a with resp_ready high; lat is edges from
  // acceptance to resp_valid, or -1 if no response arrives.
  task automatic req_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, output logic [15:0] rdata, output logic err,
                       output int lat);
    @(negedge clk);
    bus_a.req_valid  = 1'b1;
    bus_a.req_we     = we;
    bus_a.req_addr   = addr;
    bus_a.req_wdata  = wdata;
    bus_a.req_be     = be;
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    lat   = -1;
    rdata = 16'hxxxx;
    err   = 1'bx;
    for (int n = 0; n < 20; n++) begin
      if (bus_a.resp_valid) begin
        lat   = n;
        rdata = bus_a.resp_rdata;
        err   = bus_a.resp_err;
        break;
      end
      @(negedge clk);
    end
    $display("txn A we=%0d addr=%h wdata=%h be=%b -> rdata=%h err=%0d lat=%0d",
             we, addr, wdata, be, rdata, err, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = 16'd0;
    bus_a.req_wdata = 16'd0; bus_a.req_be = 2'b00; bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = 16'd0;
    bus_b.req_wdata = 16'd0; bus_b.req_be = 2'b00; bus_b.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, busy_a} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got={rdy,vld,err,busy}=%b exp=1000",
               {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, busy_a});
    end
    checks++;
    if (bus_a.resp_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0000", bus_a.resp_rdata);
    end
    checks++;
    if ({bus_b.req_ready, bus_b.resp_valid, busy_b} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl_b got=%b exp=100", {bus_b.req_ready, bus_b.resp_valid, busy_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_latency();
    int lat;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0010;
    bus_a.req_be = 2'b11; bus_a.resp_ready = 1'b1;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    checks++;
    if ({bus_a.req_ready, busy_a} !== 2'b01) begin
      failures++;
      $display("FAIL lat_ready_drop got={rdy,busy}=%b exp=01", {bus_a.req_ready, busy_a});
    end
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (bus_a.resp_valid) begin lat = n; break; end
      @(negedge clk);
    end
    $display("txn A load addr=0010 -> rdata=%h err=%0d lat=%0d", bus_a.resp_rdata, bus_a.resp_err, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL lat_edges got=%0d exp=3", lat);
    end
    checks++;
    if ({bus_a.resp_err, bus_a.resp_rdata} !== 17'h00000) begin
      failures++;
      $display("FAIL lat_data got=err%0d/%h exp=err0/0000", bus_a.resp_err, bus_a.resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.req_ready, bus_a.resp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL lat_after_hs got={rdy,vld}=%b exp=10", {bus_a.req_ready, bus_a.resp_valid});
    end
  endtask

  task automatic test_byte_enables();
    vec_t        v[8];
    logic [15:0] rd;
    logic        er;
    int          lat;
    v[0] = '{1'b1, 16'h0020, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
    v[1] = '{1'b0, 16'h0020, 16'h0000, 2'b11, 16'hBEEF, 1'b0};
    v[2] = '{1'b1, 16'h0020, 16'h1234, 2'b01, 16'h0000, 1'b0};
    v[3] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBE34, 1'b0};
    v[4] = '{1'b1, 16'h0020, 16'h5600, 2'b10, 16'h0000, 1'b0};
    v[5] = '{1'b0, 16'h0020, 16'h0000, 2'b01, 16'h5634, 1'b0};
    v[6] = '{1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000, 1'b0};
    v[7] = '{1'b0, 16'h0020, 16'h0000, 2'b11, 16'h5634, 1'b0};
    for (int i = 0; i < 8; i++) begin
      req_a(v[i].we, v[i].addr, v[i].wdata, v[i].be, rd, er, lat);
      checks++;
      if ({er, rd, 8'(lat)} !== {v[i].exp_err, v[i].exp_rdata, 8'd3}) begin
        failures++;
        $display("FAIL be_vec%0d got=err%0d/%h/lat%0d exp=err%0d/%h/lat3",
                 i, er, rd, lat, v[i].exp_err, v[i].exp_rdata);
      end
    end
  endtask

  task automatic test_range();
    vec_t        v[6];
    logic [15:0] rd;
    logic        er;
    int          lat;
    v[0] = '{1'b1, 16'h0000, 16'h1357, 2'b11, 16'h0000, 1'b0};
    v[1] = '{1'b0, 16'h0100, 16'h0000, 2'b11, 16'h0000, 1'b1};
    v[2] = '{1'b1, 16'h0100, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
    v[3] = '{1'b0, 16'h0000, 16'h0000, 2'b11, 16'h1357, 1'b0};
    v[4] = '{1'b1, 16'h00FF, 16'hA5A5, 2'b11, 16'h0000, 1'b0};
    v[5] = '{1'b0, 16'h00FF, 16'h0000, 2'b11, 16'hA5A5, 1'b0};
    for (int i = 0; i < 6; i++) begin
      req_a(v[i].we, v[i].addr, v[i].wdata, v[i].be, rd, er, lat);
      checks++;
      if ({er, rd, 8'(lat)} !== {v[i].exp_err, v[i].exp_rdata, 8'd3}) begin
        failures++;
        $display("FAIL range_vec%0d got=err%0d/%h/lat%0d exp=err%0d/%h/lat3",
                 i, er, rd, lat, v[i].exp_err, v[i].exp_rdata);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        found;
    logic        extra;
    logic [15:0] rd;
    logic        er;
    int          lat;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 16'h0020;
    bus_a.req_be = 2'b11; bus_a.resp_ready = 1'b0;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus_a.resp_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("FAIL bp_resp_seen got=%0d exp=1", found);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus_a.resp_valid, bus_a.req_ready, bus_a.resp_err, bus_a.resp_rdata} !==
          {1'b1, 1'b0, 1'b0, 16'h5634}) begin
        failures++;
        $display("FAIL bp_hold%0d got=vld%0d rdy%0d err%0d %h exp=vld1 rdy0 err0 5634", i,
                 bus_a.resp_valid, bus_a.req_ready, bus_a.resp_err, bus_a.resp_rdata);
      end
      if (i == 1) begin
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 16'h0020;
        bus_a.req_wdata = 16'hDEAD; bus_a.req_be = 2'b11;
      end
      if (i == 3) bus_a.req_valid = 1'b0;
      @(negedge clk);
    end
    $display("txn A held load addr=0020 -> rdata=%h err=%0d", bus_a.resp_rdata, bus_a.resp_err);
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_a.resp_valid, bus_a.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release got={vld,rdy}=%b exp=01", {bus_a.resp_valid, bus_a.req_ready});
    end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.resp_valid) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_extra got=%0d exp=0", extra);
    end
    req_a(1'b0, 16'h0020, 16'h0000, 2'b11, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 16'h5634}) begin
      failures++;
      $display("FAIL bp_not_written got=err%0d/%h exp=err0/5634", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[8];
    int   issued;
    int   got;
    int   cyc;
    v[0] = '{1'b1, 16'h0030, 16'h1111, 2'b11, 16'h0000, 1'b0};
    v[1] = '{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h1111, 1'b0};
    v[2] = '{1'b1, 16'h0031, 16'h2222, 2'b11, 16'h0000, 1'b0};
    v[3] = '{1'b0, 16'h0031, 16'h0000, 2'b11, 16'h2222, 1'b0};
    v[4] = '{1'b1, 16'h0030, 16'h33CC, 2'b01, 16'h0000, 1'b0};
    v[5] = '{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h11CC, 1'b0};
    v[6] = '{1'b1, 16'h00FF, 16'h4444, 2'b10, 16'h0000, 1'b0};
    v[7] = '{1'b0, 16'h00FF, 16'h0000, 2'b11, 16'h4400, 1'b0};
    issued = 0;
    got    = 0;
    cyc    = 0;
    @(negedge clk);
    bus_b.resp_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (bus_b.resp_valid) begin
        $display("txn B resp%0d rdata=%h err=%0d", got, bus_b.resp_rdata, bus_b.resp_err);
        checks++;
        if ({bus_b.resp_err, bus_b.resp_rdata} !== {v[got].exp_err, v[got].exp_rdata}) begin
          failures++;
          $display("FAIL b2b_vec%0d got=err%0d/%h exp=err%0d/%h", got,
                   bus_b.resp_err, bus_b.resp_rdata, v[got].exp_err, v[got].exp_rdata);
        end
        got++;
      end
      if (bus_b.req_ready) begin
        if (issued < 8) begin
          bus_b.req_valid = 1'b1;
          bus_b.req_we    = v[issued].we;
          bus_b.req_addr  = v[issued].addr;
          bus_b.req_wdata = v[issued].wdata;
          bus_b.req_be    = v[issued].be;
          issued++;
        end else begin
          bus_b.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus_b.req_valid = 1'b0;
    checks++;
    if (got !== 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=8", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    req_a(1'b1, 16'h0005, 16'hAAAA, 2'b11, rd, er, lat);
    checks++;
    if ({er, 8'(lat)} !== {1'b0, 8'd3}) begin
      failures++;
      $display("FAIL rm_first_store got=err%0d/lat%0d exp=err0/lat3", er, lat);
    end
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 16'h0005;
    bus_a.req_wdata = 16'h5555; bus_a.req_be = 2'b11; bus_a.resp_ready = 1'b1;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL rm_busy got=%0d exp=1", busy_a);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("txn A reset during wait (store 5555 to 0005 dropped)");
    checks++;
    if ({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, busy_a, bus_a.resp_rdata} !==
        {4'b1000, 16'h0000}) begin
      failures++;
      $display("FAIL rm_async_reset got={rdy,vld,err,busy}=%b rdata=%h exp=1000 0000",
               {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, busy_a}, bus_a.resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rm_no_resp got=%0d exp=0", seen);
    end
    req_a(1'b0, 16'h0005, 16'h0000, 2'b11, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 16'hAAAA}) begin
      failures++;
      $display("FAIL rm_persist got=err%0d/%h exp=err0/AAAA", er, rd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_latency();
    test_byte_enables();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
